aeolus_mem_arbiter: RTL and testbench

Two-port round-robin arbiter that shares the Aeolus CPU's single-port synchronous data RAM between the CPU core (port 0) and the program loader/debug port (port 1). It sits between `AeolusCPUTop`'s memory interface and the RAM. It serialises requests, registers the winning access onto the RAM pins and returns per-port read-valid strobes. Full RAM bandwidth is available when both ports are active; neither port can be starved.

---
 rtl/aeolus_pkg.sv | 28 ++
 rtl/rr_pick2.sv | 26 ++
 rtl/aeolus_mem_arbiter.sv | 117 +++++++++++
 tb/tb_aeolus_mem_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aeolus_pkg.sv
// Shared definitions for the Aeolus data-RAM arbiter: width defaults,
// port indices, access type and arbiter state encoding.
package aeolus_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    // Requester indices: the CPU core and the loader/debug port
    localparam int PORT_CPU  = 0;
    localparam int PORT_LOAD = 1;

    typedef enum logic {
        ACC_READ  = 1'b0,
        ACC_WRITE = 1'b1
    } acc_t;

    // One bit per granted port, so the grant outputs decode straight from the register
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_G0   = 2'b01,
        ST_G1   = 2'b10
    } arb_state_t;

    function automatic acc_t acc_of(input logic we);
        return we ? ACC_WRITE : ACC_READ;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way picker: one-hot winner among the effective requests,
// breaking ties either by round-robin on the last winner or by fixed priority.
module rr_pick2
    import aeolus_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic       eff0,
    input  logic       eff1,
    input  logic       last,
    output logic [1:0] win,
    output logic       any
);

    logic tie0;

    // Port 0 wins a tie when priority is fixed or when port 1 won last time
    always_comb begin
        win             = 2'b00;
        tie0            = FIXED_PRIO ? 1'b1 : last;
        win[PORT_CPU]   = eff0 & (~eff1 | tie0);
        win[PORT_LOAD]  = eff1 & ~win[PORT_CPU];
        any             = eff0 | eff1;
    end

endmodule

// File: rtl/aeolus_mem_arbiter.sv
// Two-port arbiter sharing the single-port synchronous data RAM between the
// CPU core (port 0) and the loader/debug port (port 1). The winning access is
// registered onto the RAM pins; a read returns its rvalid strobe one cycle later.
module aeolus_mem_arbiter
    import aeolus_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIXED_PRIO = 0
) (
    input  logic              boardCLK,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              memEn,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWdata,
    input  logic [DATA_W-1:0] memRdata
);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic              last;
    logic              last_nxt;
    logic              eff0;
    logic              eff1;
    logic [1:0]        win;
    logic              any;
    logic              mem_we_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] mem_wdata_nxt;

    assign gnt0 = state[PORT_CPU];
    assign gnt1 = state[PORT_LOAD];

    // A port that holds a grant this cycle is not re-sampled, so it cannot
    // win twice in a row and the other port always gets its turn
    assign eff0 = req0 & ~gnt0;
    assign eff1 = req1 & ~gnt1;

    assign rdata = memRdata;

    rr_pick2 #(
        .FIXED_PRIO (FIXED_PRIO != 0)
    ) u_pick (
        .eff0 (eff0),
        .eff1 (eff1),
        .last (last),
        .win  (win),
        .any  (any)
    );

    // Next grant state and RAM-side mux; address/data/we hold when nobody wins
    always_comb begin
        state_nxt     = ST_IDLE;
        last_nxt      = last;
        mem_we_nxt    = memWe;
        mem_addr_nxt  = memAddr;
        mem_wdata_nxt = memWdata;
        if (win[PORT_CPU]) begin
            state_nxt     = ST_G0;
            last_nxt      = 1'b0;
            mem_we_nxt    = (acc_of(we0) == ACC_WRITE);
            mem_addr_nxt  = addr0;
            mem_wdata_nxt = wdata0;
        end else if (win[PORT_LOAD]) begin
            state_nxt     = ST_G1;
            last_nxt      = 1'b1;
            mem_we_nxt    = (acc_of(we1) == ACC_WRITE);
            mem_addr_nxt  = addr1;
            mem_wdata_nxt = wdata1;
        end
    end

    // Grant state and last winner; last resets to port 1 so port 0 wins the first tie
    always_ff @(posedge boardCLK) begin
        if (reset) begin
            state <= ST_IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
        end
    end

    // RAM pins and read-return strobes; memWe here still describes the granted access
    always_ff @(posedge boardCLK) begin
        if (reset) begin
            memEn    <= 1'b0;
            memWe    <= 1'b0;
            memAddr  <= '0;
            memWdata <= '0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
        end else begin
            memEn    <= any;
            memWe    <= mem_we_nxt;
            memAddr  <= mem_addr_nxt;
            memWdata <= mem_wdata_nxt;
            rvalid0  <= gnt0 & ~memWe;
            rvalid1  <= gnt1 & ~memWe;
        end
    end

endmodule

// File: tb/tb_aeolus_mem_arbiter.sv
// Directed bench for aeolus_mem_arbiter: a round-robin instance driving a
// small synchronous RAM model, plus a fixed-priority instance for tie-break checks.
module tb_aeolus_mem_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk;
    logic          reset;

    // Round-robin instance
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata;
    logic          memEn, memWe;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memWdata;
    logic [DW-1:0] memRdata;

    // Fixed-priority instance
    logic          req0f, req1f, we0f, we1f;
    logic [AW-1:0] addr0f, addr1f;
    logic [DW-1:0] wdata0f, wdata1f;
    logic          gnt0f, gnt1f, rvalid0f, rvalid1f;
    logic [DW-1:0] rdataf;
    logic          memEnf, memWef;
    logic [AW-1:0] memAddrf;
    logic [DW-1:0] memWdataf;
    logic [DW-1:0] memRdataf;

    // RAM model with a bench-side preload port
    logic [DW-1:0] mem [0:255];
    logic          pre_en;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;

    int errors;
    int checks;

    aeolus_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0)) dut (
        .boardCLK (clk),     .reset    (reset),
        .req0     (req0),    .req1     (req1),
        .we0      (we0),     .we1      (we1),
        .addr0    (addr0),   .addr1    (addr1),
        .wdata0   (wdata0),  .wdata1   (wdata1),
        .gnt0     (gnt0),    .gnt1     (gnt1),
        .rvalid0  (rvalid0), .rvalid1  (rvalid1),
        .rdata    (rdata),
        .memEn    (memEn),   .memWe    (memWe),
        .memAddr  (memAddr), .memWdata (memWdata),
        .memRdata (memRdata)
    );

    aeolus_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1)) dut_f (
        .boardCLK (clk),      .reset    (reset),
        .req0     (req0f),    .req1     (req1f),
        .we0      (we0f),     .we1      (we1f),
        .addr0    (addr0f),   .addr1    (addr1f),
        .wdata0   (wdata0f),  .wdata1   (wdata1f),
        .gnt0     (gnt0f),    .gnt1     (gnt1f),
        .rvalid0  (rvalid0f), .rvalid1  (rvalid1f),
        .rdata    (rdataf),
        .memEn    (memEnf),   .memWe    (memWef),
        .memAddr  (memAddrf), .memWdata (memWdataf),
        .memRdata (memRdataf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_addr] <= pre_data;
        end else if (memEn) begin
            if (memWe) mem[memAddr] <= memWdata;
            else       memRdata     <= mem[memAddr];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        addr0 = 8'h01; addr1 = 8'h02;
        req0f = 1'b1; req1f = 1'b1;
        tick();
        tick();
        checks++;
        if ({gnt0, gnt1, rvalid0, rvalid1, memEn, memWe} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 000000", {gnt0, gnt1, rvalid0, rvalid1, memEn, memWe});
        end
        checks++;
        if ({memAddr, memWdata} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_data: got %h required 0000", {memAddr, memWdata});
        end
        checks++;
        if ({gnt0f, gnt1f, rvalid0f, rvalid1f, memEnf, memWef} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl_fixed: got %b required 000000", {gnt0f, gnt1f, rvalid0f, rvalid1f, memEnf, memWef});
        end
        reset = 1'b0;
        req0f = 1'b0; req1f = 1'b0;
        tick();
        checks++;
        if ({gnt0, gnt1, memEn, memAddr} !== {3'b101, 8'h01}) begin
            errors++;
            $display("FAIL reset_first_win: got g0=%b g1=%b en=%b addr=%h required 1 0 1 01", gnt0, gnt1, memEn, memAddr);
        end
        req0 = 1'b0;
        tick();
        checks++;
        if ({gnt0, gnt1, rvalid0, memAddr} !== {3'b011, 8'h02}) begin
            errors++;
            $display("FAIL reset_second_win: got g0=%b g1=%b rv0=%b addr=%h required 0 1 1 02", gnt0, gnt1, rvalid0, memAddr);
        end
        req1 = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_single_read();
        pre_en = 1'b1; pre_addr = 8'h23; pre_data = 8'hE1;
        tick();
        pre_en = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h23;
        tick();
        checks++;
        if ({gnt0, gnt1, memEn, memWe, memAddr} !== {4'b1010, 8'h23}) begin
            errors++;
            $display("FAIL read_grant: got g0=%b g1=%b en=%b we=%b addr=%h required 1 0 1 0 23", gnt0, gnt1, memEn, memWe, memAddr);
        end
        req0 = 1'b0;
        tick();
        checks++;
        if ({rvalid0, rvalid1, gnt0, rdata} !== {3'b100, 8'hE1}) begin
            errors++;
            $display("FAIL read_return: got rv0=%b rv1=%b g0=%b rdata=%h required 1 0 0 e1", rvalid0, rvalid1, gnt0, rdata);
        end
        tick();
        checks++;
        if ({rvalid0, rvalid1} !== 2'b00) begin
            errors++;
            $display("FAIL read_strobe_len: got %b required 00", {rvalid0, rvalid1});
        end
    endtask

    task automatic test_write_read_p1();
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h40; wdata1 = 8'h5A;
        tick();
        checks++;
        if ({gnt1, memEn, memWe, memAddr, memWdata} !== {3'b111, 8'h40, 8'h5A}) begin
            errors++;
            $display("FAIL write_grant: got g1=%b en=%b we=%b addr=%h wd=%h required 1 1 1 40 5a", gnt1, memEn, memWe, memAddr, memWdata);
        end
        req1 = 1'b0;
        tick();
        checks++;
        if ({rvalid0, rvalid1} !== 2'b00) begin
            errors++;
            $display("FAIL write_no_rvalid: got %b required 00", {rvalid0, rvalid1});
        end
        req1 = 1'b1; we1 = 1'b0;
        tick();
        checks++;
        if ({gnt1, memWe, memAddr} !== {2'b10, 8'h40}) begin
            errors++;
            $display("FAIL readback_grant: got g1=%b we=%b addr=%h required 1 0 40", gnt1, memWe, memAddr);
        end
        req1 = 1'b0;
        tick();
        checks++;
        if ({rvalid1, rvalid0, rdata} !== {2'b10, 8'h5A}) begin
            errors++;
            $display("FAIL readback_data: got rv1=%b rv0=%b rdata=%h required 1 0 5a", rvalid1, rvalid0, rdata);
        end
        tick();
    endtask

    task automatic test_contention();
        // Port 1 won last, so port 0 takes the first tie
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h23;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h40;
        for (int i = 0; i < 8; i++) begin
            logic exp_g0, exp_rv0, exp_rv1;
            tick();
            exp_g0  = (i % 2 == 0);
            exp_rv0 = (i >= 1) && ((i - 1) % 2 == 0);
            exp_rv1 = (i >= 1) && ((i - 1) % 2 == 1);
            checks++;
            if ({gnt0, gnt1, memEn} !== {exp_g0, ~exp_g0, 1'b1}) begin
                errors++;
                $display("FAIL contention_cycle%0d: got g0=%b g1=%b en=%b required %b %b 1", i, gnt0, gnt1, memEn, exp_g0, ~exp_g0);
            end
            checks++;
            if ({rvalid0, rvalid1} !== {exp_rv0, exp_rv1}) begin
                errors++;
                $display("FAIL contention_rvalid%0d: got %b%b required %b%b", i, rvalid0, rvalid1, exp_rv0, exp_rv1);
            end
            if (exp_rv0 || exp_rv1) begin
                checks++;
                if (rdata !== (exp_rv0 ? 8'hE1 : 8'h5A)) begin
                    errors++;
                    $display("FAIL contention_rdata%0d: got %h required %h", i, rdata, exp_rv0 ? 8'hE1 : 8'h5A);
                end
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
        checks++;
        if ({gnt0, gnt1, memEn, rvalid1} !== 4'b0001) begin
            errors++;
            $display("FAIL contention_drain: got g0=%b g1=%b en=%b rv1=%b required 0 0 0 1", gnt0, gnt1, memEn, rvalid1);
        end
        tick();
    endtask

    task automatic test_tie_break();
        // Port 0 wins alone on both instances, then both ports request together
        req0 = 1'b1; addr0 = 8'h23; we0 = 1'b0;
        req0f = 1'b1;
        tick();
        req0 = 1'b0; req0f = 1'b0;
        tick();
        req0 = 1'b1; req1 = 1'b1; req0f = 1'b1; req1f = 1'b1;
        for (int i = 0; i < 6; i++) begin
            logic exp_rr1, exp_fx0;
            tick();
            exp_rr1 = (i % 2 == 0);
            exp_fx0 = (i % 2 == 0);
            checks++;
            if ({gnt0, gnt1} !== {~exp_rr1, exp_rr1}) begin
                errors++;
                $display("FAIL rr_tie%0d: got g0=%b g1=%b required %b %b", i, gnt0, gnt1, ~exp_rr1, exp_rr1);
            end
            checks++;
            if ({gnt0f, gnt1f, memEnf} !== {exp_fx0, ~exp_fx0, 1'b1}) begin
                errors++;
                $display("FAIL fixed_tie%0d: got g0=%b g1=%b en=%b required %b %b 1", i, gnt0f, gnt1f, memEnf, exp_fx0, ~exp_fx0);
            end
        end
        req0 = 1'b0; req1 = 1'b0; req0f = 1'b0; req1f = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_during_read();
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h23;
        tick();
        checks++;
        if ({gnt0, memEn, memWe} !== 3'b110) begin
            errors++;
            $display("FAIL rst_read_grant: got g0=%b en=%b we=%b required 1 1 0", gnt0, memEn, memWe);
        end
        reset = 1'b1; req0 = 1'b0;
        tick();
        checks++;
        if ({gnt0, memEn, rvalid0} !== 3'b000) begin
            errors++;
            $display("FAIL rst_read_clear: got g0=%b en=%b rv0=%b required 0 0 0", gnt0, memEn, rvalid0);
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({gnt0, memEn, rvalid0} !== 3'b000) begin
            errors++;
            $display("FAIL rst_read_after: got g0=%b en=%b rv0=%b required 0 0 0", gnt0, memEn, rvalid0);
        end
    endtask

    task automatic test_idle_hold();
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h10; wdata1 = 8'h77;
        tick();
        checks++;
        if ({gnt1, memWe, memAddr} !== {2'b11, 8'h10}) begin
            errors++;
            $display("FAIL idle_write_grant: got g1=%b we=%b addr=%h required 1 1 10", gnt1, memWe, memAddr);
        end
        req1 = 1'b0; we1 = 1'b0; addr1 = 8'h99; wdata1 = 8'h00;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({memEn, rvalid1, memWe, memAddr, memWdata} !== {3'b001, 8'h10, 8'h77}) begin
                errors++;
                $display("FAIL idle_hold%0d: got en=%b rv1=%b we=%b addr=%h wd=%h required 0 0 1 10 77", i, memEn, rvalid1, memWe, memAddr, memWdata);
            end
        end
        checks++;
        if (mem[8'h10] !== 8'h77) begin
            errors++;
            $display("FAIL idle_ram_contents: got %h required 77", mem[8'h10]);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        req0f = 1'b0; req1f = 1'b0; we0f = 1'b0; we1f = 1'b0;
        addr0f = 8'h05; addr1f = 8'h06; wdata0f = '0; wdata1f = '0;
        memRdataf = '0;
        pre_en = 1'b0; pre_addr = '0; pre_data = '0;

        test_reset();
        test_single_read();
        test_write_read_p1();
        test_contention();
        test_tie_break();
        test_reset_during_read();
        test_idle_hold();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
